mb_conf_builder: RTL

Per-macroblock sign-group census on the encode side. It counts signed coefficients per group (motion, selected/unselected for groups 1–6) as they stream past. At each macroblock end it writes one packed configuration word into the mb_conf FIFO. That word carries the 13×7-bit counts, the first-group code and the single-group flag in exactly the layout the downstream switcher consumes.

---
 rtl/mb_conf_builder_if.sv | 26 ++
 rtl/mb_conf_builder.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mb_conf_builder_if.sv
// mb_conf_builder bus: sign stream in, mb_conf FIFO write side out.
// master = upstream/FIFO side, slave = the builder.
interface mb_conf_builder_if;
   logic        sign_valid;
   logic [3:0]  sign_group;
   logic        mb_end;
   logic        in_ready;
   logic        mb_conf_afull;
   logic [90:0] mb_conf;
   logic [2:0]  first_group;
   logic        has_one_group;
   logic        mb_conf_wr;
   logic        group_err;

   modport master (
      output sign_valid, sign_group, mb_end, mb_conf_afull,
      input  in_ready, mb_conf, first_group, has_one_group,
      input  mb_conf_wr, group_err
   );

   modport slave (
      input  sign_valid, sign_group, mb_end, mb_conf_afull,
      output in_ready, mb_conf, first_group, has_one_group,
      output mb_conf_wr, group_err
   );
endinterface

// File: rtl/mb_conf_builder.sv
// Per-macroblock sign-group census; one packed word per MB to mb_conf FIFO.
// Ports: clk, rst (sync, high), clk_en, bus (sign in / mb_conf out).
module mb_conf_builder (
   input  logic               clk,
   input  logic               rst,
   input  logic               clk_en,
   mb_conf_builder_if.slave   bus
);

   logic [6:0]  cnt_q  [13];
   logic [6:0]  cnt_d  [13];
   logic [6:0]  cnt_nx [13];
   logic [12:0] nz;

   logic [90:0] snap_w;
   logic [2:0]  fg_w;
   logic        one_w;

   // Snapshot waiting to be written.
   logic [90:0] snap_conf_q, snap_conf_d;
   logic [2:0]  snap_fg_q, snap_fg_d;
   logic        snap_one_q, snap_one_d;
   logic        pending_q, pending_d;

   // Word presented alongside the write strobe.
   logic [90:0] conf_q, conf_d;
   logic [2:0]  fg_q, fg_d;
   logic        one_q, one_d;
   logic        wr_q, wr_d;
   logic        err_q, err_d;

   logic        accept;
   logic        drain;
   logic        capture;

   assign bus.in_ready      = ~(pending_q & bus.mb_conf_afull);
   assign bus.mb_conf       = conf_q;
   assign bus.first_group   = fg_q;
   assign bus.has_one_group = one_q;
   assign bus.mb_conf_wr    = wr_q & clk_en;
   assign bus.group_err     = err_q;

   always_comb begin
      accept = clk_en & bus.in_ready;
      drain  = clk_en & pending_q & ~bus.mb_conf_afull;

      snap_w = '0;
      for (int i = 0; i < 13; i++) begin
         cnt_nx[i] = cnt_q[i];
         if (accept && bus.sign_valid &&
             bus.sign_group == 4'(i) &&
             cnt_q[i] != 7'h7f)
            cnt_nx[i] = cnt_q[i] + 7'd1;
         nz[i] = |cnt_nx[i];
         snap_w[90-7*i -: 7] = cnt_nx[i];
      end

      one_w = $onehot(nz);

      // Lowest-numbered non-empty group wins; motion beats all.
      fg_w = 3'd0;
      if (!nz[0]) begin
         for (int k = 6; k >= 1; k--) begin
            if (nz[2*k-1] || nz[2*k])
               fg_w = 3'(k);
         end
      end

      capture = accept & bus.mb_end & (|nz);

      cnt_d       = cnt_q;
      snap_conf_d = snap_conf_q;
      snap_fg_d   = snap_fg_q;
      snap_one_d  = snap_one_q;
      conf_d      = conf_q;
      fg_d        = fg_q;
      one_d       = one_q;
      err_d       = err_q;

      if (accept) begin
         cnt_d = cnt_nx;
         if (bus.mb_end)
            cnt_d = '{default: '0};
      end

      if (accept && bus.sign_valid && bus.sign_group > 4'd12)
         err_d = 1'b1;

      // Drain moves the old snapshot out before a new one lands.
      if (drain) begin
         conf_d = snap_conf_q;
         fg_d   = snap_fg_q;
         one_d  = snap_one_q;
      end

      if (capture) begin
         snap_conf_d = snap_w;
         snap_fg_d   = fg_w;
         snap_one_d  = one_w;
      end

      pending_d = capture | (pending_q & ~drain);

      // Strobe holds across clk_en low so a gated FIFO still sees it.
      wr_d = clk_en ? drain : wr_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '{default: '0};
         snap_conf_q <= '0;
         snap_fg_q   <= '0;
         snap_one_q  <= 1'b0;
         pending_q   <= 1'b0;
         conf_q      <= '0;
         fg_q        <= '0;
         one_q       <= 1'b0;
         wr_q        <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         snap_conf_q <= snap_conf_d;
         snap_fg_q   <= snap_fg_d;
         snap_one_q  <= snap_one_d;
         pending_q   <= pending_d;
         conf_q      <= conf_d;
         fg_q        <= fg_d;
         one_q       <= one_d;
         wr_q        <= wr_d;
         err_q       <= err_d;
      end
   end

endmodule
